imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ERR_W, default 8, giving the width of the illegal-opcode counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous buffer clear.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream instruction is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept an instruction.
REQ-008 The block SHALL have port instruction, input, 32 bits: the raw RV32 instruction word.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the output entry is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output entry.
REQ-011 The block SHALL have port ImmExt, output, XLEN bits: the sign-extended immediate.
REQ-012 The block SHALL have port imm_type, output, 3 bits: the format code (0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal).
REQ-013 The block SHALL have port illegal, output, 1 bit: the opcode is not in the supported set.
REQ-014 The block SHALL have port err_count, output, ERR_W bits: a saturating count of accepted illegal instructions.

Function
REQ-015 A push SHALL occur when in_valid and in_ready are both high at the clock edge, and a pop SHALL occur when out_valid and out_ready are both high at the clock edge.
REQ-016 Decode SHALL be combinational on instruction, and the decoded result SHALL be stored into a 2-entry FIFO at push.
REQ-017 Outputs SHALL be driven from the FIFO head only, so latency is 1 cycle: a push at edge N gives out_valid high after edge N when the FIFO was empty.
REQ-018 in_ready SHALL equal (count < 2) and SHALL NOT depend on out_ready, so there is no combinational ready path.
REQ-019 A simultaneous push and pop with count=1 SHALL leave count=1, with the head advancing to the new entry, and SHALL sustain one instruction per cycle.
REQ-020 When count=2, in_ready SHALL be low and no push SHALL occur, even if a pop happens in the same cycle.
REQ-021 When count=0, out_valid SHALL be low and ImmExt, imm_type and illegal SHALL be 0.
REQ-022 The read and write pointers SHALL be 1 bit each and SHALL wrap modulo 2.
REQ-023 Opcodes 0000011, 0010011 and 1100111 SHALL decode as type I with imm = sext(instruction[31:20]).
REQ-024 Opcode 0100011 SHALL decode as type S with imm = sext({instruction[31:25], instruction[11:7]}).
REQ-025 Opcode 1100011 SHALL decode as type B with imm = sext({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 0}).
REQ-026 Opcodes 0110111 and 0010111 SHALL decode as type U with imm = sext({instruction[31:12], 12'b0}).
REQ-027 Opcode 1101111 SHALL decode as type J with imm = sext({instruction[31], instruction[19:12], instruction[20], instruction[30:21], 0}).
REQ-028 Opcode 0110011 SHALL decode as type R with imm = 0 and illegal = 0.
REQ-029 Any other opcode SHALL decode as type 7 with imm = 0 and illegal = 1.
REQ-030 Sign extension SHALL replicate instruction[31] up to XLEN bits.
REQ-031 err_count SHALL increment by 1 on each push whose decode is illegal, and SHALL saturate at 2^ERR_W-1 with no wrap.
REQ-032 When flush is high at an edge, count and both pointers SHALL be set to 0, and any push or pop in that cycle SHALL be ignored (flush wins).
REQ-033 flush SHALL NOT change err_count, and an illegal push dropped by flush SHALL NOT be counted.

Reset
REQ-034 While reset is high, the block SHALL asynchronously force count=0, both pointers to 0, err_count=0 and FIFO contents to 0, giving out_valid=0, in_ready=1, ImmExt=0, imm_type=0 and illegal=0.
REQ-035 A reset mid-operation SHALL discard all buffered entries, and no pop SHALL be reported afterwards.
REQ-036 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-037 Push 0xFFC12083 (lw) -> one cycle later out_valid=1, ImmExt=0xFFFFFFFC, imm_type=1, illegal=0.
REQ-038 Push 0x00512423 (sw), 0xFE000CE3 (beq), 0x123450B7 (lui) and 0x001000EF (jal) back-to-back with out_ready=1 -> ImmExt = 0x00000008, 0xFFFFFFF8, 0x12345000, 0x00000800 in order, with one output per cycle and in_ready held at 1.
REQ-039 Hold out_ready=0 and push three instructions -> in_ready=0 after 2 accepts and the third is held upstream; raise out_ready -> entries drain in order and the third is accepted.
REQ-040 Push 0x0000007F 300 times with ERR_W=8 -> illegal=1, ImmExt=0, imm_type=7, and err_count saturates at 255.
REQ-041 With count=2, assert flush together with in_valid=1 -> the next cycle has out_valid=0, count=0 and err_count unchanged.
REQ-042 With XLEN=64, push 0xFFC12083 -> ImmExt=0xFFFFFFFFFFFFFFFC; assert reset asynchronously while count=1 -> out_valid drops before the next clock edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator with a 2-entry output FIFO.
// Decode is combinational; outputs come only from the FIFO head, so the block has one cycle of latency.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ImmExt,
   output logic [2:0]       imm_type,
   output logic             illegal,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [2:0] {
      IMM_R   = 3'd0,
      IMM_I   = 3'd1,
      IMM_S   = 3'd2,
      IMM_B   = 3'd3,
      IMM_U   = 3'd4,
      IMM_J   = 3'd5,
      IMM_BAD = 3'd7
   } imm_type_e;

   imm_type_e        dec_type;
   logic             dec_illegal;
   logic [31:0]      dec_imm32;
   logic [XLEN-1:0]  dec_imm;

   logic [XLEN-1:0]  imm_q  [2];
   logic [2:0]       type_q [2];
   logic             ill_q  [2];
   logic [1:0]       count;
   logic             wptr;
   logic             rptr;
   logic             push;
   logic             pop;

   // The immediate is assembled at 32 bits, then widened with a signed cast so bit 31 fills any upper bits.
   always_comb begin
      dec_type    = IMM_BAD;
      dec_illegal = 1'b1;
      dec_imm32   = '0;
      case (instruction[6:0])
         7'b0000011, 7'b0010011, 7'b1100111: begin
            dec_type    = IMM_I;
            dec_illegal = 1'b0;
            dec_imm32   = {{20{instruction[31]}}, instruction[31:20]};
         end
         7'b0100011: begin
            dec_type    = IMM_S;
            dec_illegal = 1'b0;
            dec_imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         end
         7'b1100011: begin
            dec_type    = IMM_B;
            dec_illegal = 1'b0;
            dec_imm32   = {{19{instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            dec_type    = IMM_U;
            dec_illegal = 1'b0;
            dec_imm32   = {instruction[31:12], 12'b0};
         end
         7'b1101111: begin
            dec_type    = IMM_J;
            dec_illegal = 1'b0;
            dec_imm32   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                           instruction[20], instruction[30:21], 1'b0};
         end
         7'b0110011: begin
            dec_type    = IMM_R;
            dec_illegal = 1'b0;
         end
         default: begin
            dec_type    = IMM_BAD;
            dec_illegal = 1'b1;
         end
      endcase
      dec_imm = XLEN'($signed(dec_imm32));
   end

   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Stale head contents remain after a pop, so an empty FIFO masks its outputs to zero.
   assign ImmExt   = out_valid ? imm_q[rptr]  : '0;
   assign imm_type = out_valid ? type_q[rptr] : 3'd0;
   assign illegal  = out_valid ? ill_q[rptr]  : 1'b0;

   // Flush drops any push or pop in its cycle, so an illegal instruction it discards is never counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= 2'd0;
         wptr      <= 1'b0;
         rptr      <= 1'b0;
         err_count <= '0;
         for (int i = 0; i < 2; i++) begin
            imm_q[i]  <= '0;
            type_q[i] <= 3'd0;
            ill_q[i]  <= 1'b0;
         end
      end else if (flush) begin
         count <= 2'd0;
         wptr  <= 1'b0;
         rptr  <= 1'b0;
      end else begin
         if (push) begin
            imm_q[wptr]  <= dec_imm;
            type_q[wptr] <= dec_type;
            ill_q[wptr]  <= dec_illegal;
            wptr         <= ~wptr;
            if (dec_illegal && (err_count != {ERR_W{1'b1}})) begin
               err_count <= err_count + 1'b1;
            end
         end
         if (pop) begin
            rptr <= ~rptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: a decode vector table, then handshake, flush,
// saturation and XLEN=64 reset sequences.
module tb_imm_gen_pipe;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ImmExt;
   logic [2:0]  imm_type;
   logic        illegal;
   logic [7:0]  err_count;

   logic        reset64;
   logic        flush64;
   logic        in_valid64;
   logic        in_ready64;
   logic [31:0] instruction64;
   logic        out_valid64;
   logic        out_ready64;
   logic [63:0] ImmExt64;
   logic [2:0]  imm_type64;
   logic        illegal64;
   logic [7:0]  err_count64;

   int checks;
   int passes;
   int err_model;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] exp_imm;
      logic [2:0]  exp_type;
      logic        exp_ill;
   } vec_t;

   vec_t        vecs [11];
   logic [31:0] b2b_instr [4];
   logic [31:0] b2b_imm   [4];

   imm_gen_pipe #(.XLEN(32), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
      .out_valid(out_valid), .out_ready(out_ready),
      .ImmExt(ImmExt), .imm_type(imm_type), .illegal(illegal), .err_count(err_count)
   );

   imm_gen_pipe #(.XLEN(64), .ERR_W(8)) dut64 (
      .clk(clk), .reset(reset64), .flush(flush64),
      .in_valid(in_valid64), .in_ready(in_ready64), .instruction(instruction64),
      .out_valid(out_valid64), .out_ready(out_ready64),
      .ImmExt(ImmExt64), .imm_type(imm_type64), .illegal(illegal64), .err_count(err_count64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic ordy);
      in_valid    = v;
      instruction = instr;
      out_ready   = ordy;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end else begin
         passes++;
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   initial begin
      checks    = 0;
      passes    = 0;
      err_model = 0;

      vecs[0]  = '{32'hFFC12083, 32'hFFFFFFFC, 3'd1, 1'b0};
      vecs[1]  = '{32'h00512423, 32'h00000008, 3'd2, 1'b0};
      vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
      vecs[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0};
      vecs[4]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0};
      vecs[5]  = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0};
      vecs[6]  = '{32'h7FF00093, 32'h000007FF, 3'd1, 1'b0};
      vecs[7]  = '{32'h800080E7, 32'hFFFFF800, 3'd1, 1'b0};
      vecs[8]  = '{32'hFFFFF117, 32'hFFFFF000, 3'd4, 1'b0};
      vecs[9]  = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};
      vecs[10] = '{32'h0000000B, 32'h00000000, 3'd7, 1'b1};

      b2b_instr = '{32'h00512423, 32'hFE000CE3, 32'h123450B7, 32'h001000EF};
      b2b_imm   = '{32'h00000008, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};

      reset = 1'b1;
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0);
      reset64       = 1'b1;
      flush64       = 1'b0;
      in_valid64    = 1'b0;
      instruction64 = 32'h0;
      out_ready64   = 1'b0;

      step();
      checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("rst_imm", {32'd0, ImmExt}, 64'd0);
      checkOutput("rst_type", {61'd0, imm_type}, 64'd0);
      checkOutput("rst_illegal", {63'd0, illegal}, 64'd0);
      checkOutput("rst_err_count", {56'd0, err_count}, 64'd0);
      reset = 1'b0;

      // Table: each vector is pushed, checked at the head one cycle later, then popped.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b1, vecs[i].instr, 1'b1);
         step();
         applyStimulus(1'b0, 32'h0, 1'b1);
         if (vecs[i].exp_ill) err_model = sat_inc(err_model);
         checkOutput($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
         checkOutput($sformatf("vec%0d_imm", i), {32'd0, ImmExt}, {32'd0, vecs[i].exp_imm});
         checkOutput($sformatf("vec%0d_type", i), {61'd0, imm_type}, {61'd0, vecs[i].exp_type});
         checkOutput($sformatf("vec%0d_illegal", i), {63'd0, illegal}, {63'd0, vecs[i].exp_ill});
         checkOutput($sformatf("vec%0d_err_count", i), {56'd0, err_count}, 64'(err_model));
         step();
         checkOutput($sformatf("vec%0d_empty_valid", i), {63'd0, out_valid}, 64'd0);
         checkOutput($sformatf("vec%0d_empty_imm", i), {32'd0, ImmExt}, 64'd0);
      end

      // Back-to-back stream with out_ready high: one result per cycle, in_ready never drops.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, b2b_instr[i], 1'b1);
         checkOutput($sformatf("b2b%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
         step();
         checkOutput($sformatf("b2b%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
         checkOutput($sformatf("b2b%0d_imm", i), {32'd0, ImmExt}, {32'd0, b2b_imm[i]});
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      step();
      checkOutput("b2b_drained", {63'd0, out_valid}, 64'd0);

      // Backpressure: the third instruction waits upstream until space frees up.
      applyStimulus(1'b1, 32'hFFC12083, 1'b0);
      step();
      applyStimulus(1'b1, 32'h7FF00093, 1'b0);
      step();
      checkOutput("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("bp_head_a", {32'd0, ImmExt}, 64'hFFFFFFFC);
      applyStimulus(1'b1, 32'h00512423, 1'b0);
      step();
      checkOutput("bp_held_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("bp_held_head_a", {32'd0, ImmExt}, 64'hFFFFFFFC);
      applyStimulus(1'b1, 32'h00512423, 1'b1);
      step();
      checkOutput("bp_pop_a_head_b", {32'd0, ImmExt}, 64'h000007FF);
      checkOutput("bp_pop_a_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      checkOutput("bp_head_c", {32'd0, ImmExt}, 64'h00000008);
      checkOutput("bp_head_c_valid", {63'd0, out_valid}, 64'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      step();
      checkOutput("bp_drained", {63'd0, out_valid}, 64'd0);

      // Flush while full with an illegal instruction offered: all of it is dropped.
      applyStimulus(1'b1, 32'hFFC12083, 1'b0);
      step();
      applyStimulus(1'b1, 32'h00512423, 1'b0);
      step();
      flush = 1'b1;
      applyStimulus(1'b1, 32'h0000007F, 1'b0);
      step();
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("flush_full_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("flush_full_in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("flush_full_err", {56'd0, err_count}, 64'(err_model));
      flush = 1'b1;
      applyStimulus(1'b1, 32'h0000007F, 1'b1);
      step();
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("flush_empty_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("flush_empty_err", {56'd0, err_count}, 64'(err_model));
      applyStimulus(1'b1, 32'h123450B7, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("post_flush_imm", {32'd0, ImmExt}, 64'h12345000);
      step();

      // Saturation: 300 illegal pushes drive the counter to its ceiling without wrapping.
      applyStimulus(1'b1, 32'h0000007F, 1'b1);
      for (int i = 0; i < 300; i++) begin
         step();
         err_model = sat_inc(err_model);
         if (i == 0) begin
            checkOutput("sat_illegal", {63'd0, illegal}, 64'd1);
            checkOutput("sat_imm", {32'd0, ImmExt}, 64'd0);
            checkOutput("sat_type", {61'd0, imm_type}, 64'd7);
         end
      end
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("sat_err_count", {56'd0, err_count}, 64'(err_model));
      checkOutput("sat_err_ceiling", {56'd0, err_count}, 64'd255);
      step();

      // XLEN=64 instance: sign extension to 64 bits, then an asynchronous reset mid-cycle.
      reset64 = 1'b0;
      in_valid64    = 1'b1;
      instruction64 = 32'hFFC12083;
      step();
      in_valid64 = 1'b0;
      checkOutput("x64_out_valid", {63'd0, out_valid64}, 64'd1);
      checkOutput("x64_imm", ImmExt64, 64'hFFFFFFFFFFFFFFFC);
      checkOutput("x64_type", {61'd0, imm_type64}, 64'd1);
      #2;
      reset64 = 1'b1;
      #1;
      checkOutput("x64_async_valid", {63'd0, out_valid64}, 64'd0);
      checkOutput("x64_async_imm", ImmExt64, 64'd0);
      checkOutput("x64_async_in_ready", {63'd0, in_ready64}, 64'd1);
      step();
      reset64 = 1'b0;
      step();
      checkOutput("x64_no_stale_pop", {63'd0, out_valid64}, 64'd0);
      in_valid64    = 1'b1;
      instruction64 = 32'h001000EF;
      step();
      in_valid64 = 1'b0;
      checkOutput("x64_first_push_valid", {63'd0, out_valid64}, 64'd1);
      checkOutput("x64_first_push_imm", ImmExt64, 64'h0000000000000800);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
